// File: rtl/jpeg_frame_sched_if.sv
// Packed-word stream from jpeg_frame_sched toward a valid/ready sink
// (file writer, DMA or ether MAC).
interface jpeg_frame_sched_if;
  logic [31:0] word_data;
  logic [2:0]  word_bytes;
  logic        word_last;
  logic        word_valid;
  logic        word_ready;

  modport master (output word_data, word_bytes, word_last, word_valid, input word_ready);
  modport slave  (input word_data, word_bytes, word_last, word_valid, output word_ready);
endinterface

// File: rtl/jpeg_frame_sched.sv
// Frame sequencer for jpeg_enc: arms on a vsync edge, packs encoder bytes into
// little-endian 32-bit words and queues them toward a valid/ready sink.
module jpeg_frame_sched #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int W_FRM          = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [W_FRM-1:0]   frames_to_enc,
  input  logic               cam_vsync,
  output logic               encoder_active,
  input  logic               data_valid,
  input  logic [7:0]         data_out,
  input  logic               pic_ready,
  jpeg_frame_sched_if.master stream,
  output logic [W_FRM-1:0]   frame_idx,
  output logic               busy,
  output logic               done,
  output logic               err_overflow,
  output logic               err_timeout
);

  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic             vsync_p1;
  logic [W_FRM-1:0] target;
  logic [WD_W-1:0]  wd_cnt;
  logic [2:0]       pack_cnt;
  logic [31:0]      pack_data;

  logic [35:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      fifo_cnt;
  logic [35:0]      fifo_head;
  logic             head_vld;

  logic             accept_start, abort_hit, run_live, vsync_rise;
  logic [2:0]       byte_cnt;
  logic [31:0]      byte_word;
  logic [W_FRM-1:0] frame_nxt;
  logic             push_req, push_last, frame_end, wd_fire;
  logic             pack_clr, pack_load;
  logic             fifo_full, fifo_pop, fifo_push, overflow;

  function automatic logic [31:0] insert_byte(input logic [31:0] w,
                                              input logic [1:0]  slot,
                                              input logic [7:0]  b);
    logic [31:0] r;
    r = w;
    r[{slot, 3'b000} +: 8] = b;
    return r;
  endfunction

  assign abort_hit    = abort && (state != S_IDLE);
  assign accept_start = (state == S_IDLE) && start && (frames_to_enc != '0);
  assign run_live     = (state == S_RUN) && !abort;
  assign vsync_rise   = cam_vsync && !vsync_p1;

  // A same-cycle byte is merged before any push, so one push covers both events.
  assign byte_word = data_valid ? insert_byte(pack_data, pack_cnt[1:0], data_out) : pack_data;
  assign byte_cnt  = pack_cnt + {2'b00, data_valid};
  assign frame_nxt = frame_idx + W_FRM'(1);

  always_comb begin
    state_nxt = state;
    push_req  = 1'b0;
    push_last = 1'b0;
    frame_end = 1'b0;
    wd_fire   = 1'b0;
    case (state)
      S_IDLE:  if (accept_start) state_nxt = S_ARM;
      S_ARM:   if (vsync_rise) state_nxt = S_RUN;
      S_RUN: begin
        if (pic_ready) begin
          push_req  = 1'b1;
          push_last = 1'b1;
          frame_end = 1'b1;
          if (frame_nxt == target) state_nxt = S_DRAIN;
        end else if (data_valid) begin
          push_req = (byte_cnt == 3'd4);
        end else if (wd_cnt == WD_LAST) begin
          wd_fire   = 1'b1;
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: if (fifo_cnt == '0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort_hit) begin
      state_nxt = S_IDLE;
      push_req  = 1'b0;
      push_last = 1'b0;
      frame_end = 1'b0;
      wd_fire   = 1'b0;
    end
  end

  assign pack_clr  = accept_start || abort_hit || push_req;
  assign pack_load = run_live && data_valid;

  assign head_vld  = (fifo_cnt != '0);
  assign fifo_head = fifo_mem[rd_ptr];
  assign fifo_full = (fifo_cnt == FULL_CNT);
  assign fifo_pop  = head_vld && stream.word_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign fifo_push = push_req && (!fifo_full || fifo_pop);
  assign overflow  = push_req && fifo_full && !fifo_pop;

  assign stream.word_valid = head_vld;
  assign stream.word_data  = head_vld ? fifo_head[31:0]  : '0;
  assign stream.word_bytes = head_vld ? fifo_head[34:32] : '0;
  assign stream.word_last  = head_vld ? fifo_head[35]    : 1'b0;

  assign encoder_active = (state == S_RUN);
  assign busy           = (state != S_IDLE);
  assign done           = (state == S_DONE) && !abort;

  // Control state
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      vsync_p1     <= 1'b0;
      target       <= '0;
      frame_idx    <= '0;
      pack_cnt     <= '0;
      wd_cnt       <= '0;
      err_overflow <= 1'b0;
      err_timeout  <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
    end else begin
      state    <= state_nxt;
      vsync_p1 <= cam_vsync;

      if (accept_start) target <= frames_to_enc;

      if (accept_start)   frame_idx <= '0;
      else if (frame_end) frame_idx <= frame_nxt;

      if (pack_clr)       pack_cnt <= '0;
      else if (pack_load) pack_cnt <= byte_cnt;

      if ((state != S_RUN) || data_valid || pic_ready) wd_cnt <= '0;
      else                                             wd_cnt <= wd_cnt + WD_W'(1);

      if (accept_start)  err_overflow <= 1'b0;
      else if (overflow) err_overflow <= 1'b1;

      if (accept_start) err_timeout <= 1'b0;
      else if (wd_fire) err_timeout <= 1'b1;

      if (abort_hit) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fifo_cnt <= '0;
      end else begin
        if (fifo_push) wr_ptr <= wr_ptr + AW'(1);
        if (fifo_pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({fifo_push, fifo_pop})
          2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
          2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
          default: fifo_cnt <= fifo_cnt;
        endcase
      end
    end
  end

  // Data path: pack register and word storage
  always_ff @(posedge clk) begin
    if (pack_clr)       pack_data <= '0;
    else if (pack_load) pack_data <= byte_word;
    if (fifo_push) fifo_mem[wr_ptr] <= {push_last, byte_cnt, byte_word};
  end

endmodule

// File: tb/tb_jpeg_frame_sched.sv
// Directed bench for jpeg_frame_sched: byte order, frame ends, multi-frame runs,
// backpressure/overflow, watchdog, abort and start guards.
module tb_jpeg_frame_sched;

  logic        clk = 1'b0;
  logic        rst, start, abort, cam_vsync, data_valid, pic_ready;
  logic [15:0] frames_to_enc;
  logic [7:0]  data_out;
  logic        encoder_active, busy, done, err_overflow, err_timeout;
  logic [15:0] frame_idx;

  jpeg_frame_sched_if wif();

  jpeg_frame_sched #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(16), .W_FRM(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .frames_to_enc(frames_to_enc), .cam_vsync(cam_vsync),
    .encoder_active(encoder_active), .data_valid(data_valid),
    .data_out(data_out), .pic_ready(pic_ready), .stream(wif),
    .frame_idx(frame_idx), .busy(busy), .done(done),
    .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] cap_data[$];
  logic [2:0]  cap_bytes[$];
  logic        cap_last[$];
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (wif.word_valid && wif.word_ready) begin
      cap_data.push_back(wif.word_data);
      cap_bytes.push_back(wif.word_bytes);
      cap_last.push_back(wif.word_last);
    end
    if (done) done_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench stalled");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [15:0] f);
    frames_to_enc = f;
    start = 1'b1;
    tick();
    start = 1'b0;
    cam_vsync = 1'b1;
    tick();
    cam_vsync = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic pr);
    data_valid = 1'b1;
    data_out   = b;
    pic_ready  = pr;
    tick();
    data_valid = 1'b0;
    pic_ready  = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    int n = 0;
    while (busy && n < limit) begin
      tick();
      n++;
    end
    ok = !busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; cam_vsync = 1'b0;
    data_valid = 1'b0; pic_ready = 1'b0; data_out = '0; frames_to_enc = '0;
    wif.word_ready = 1'b1;
    tick(); tick();
    n_cmp++; if ({encoder_active, busy, done} !== 3'b000) begin n_err++;
      $display("FAIL rst_ctrl: got act/busy/done=%b want 000", {encoder_active, busy, done}); end
    n_cmp++; if ({wif.word_valid, wif.word_last, wif.word_bytes} !== 5'b0) begin n_err++;
      $display("FAIL rst_word_flags: got %b want 00000", {wif.word_valid, wif.word_last, wif.word_bytes}); end
    n_cmp++; if (wif.word_data !== 32'h0) begin n_err++;
      $display("FAIL rst_word_data: got %h want 00000000", wif.word_data); end
    n_cmp++; if ({frame_idx, err_overflow, err_timeout} !== 18'h0) begin n_err++;
      $display("FAIL rst_cnt_err: got idx=%0d ovf=%b to=%b want 0", frame_idx, err_overflow, err_timeout); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_byte_order();
    int q0 = cap_data.size();
    int d0 = done_cnt;
    bit ok;
    start_run(16'd1);
    n_cmp++; if (encoder_active !== 1'b1) begin n_err++;
      $display("FAIL bo_active: got %b want 1", encoder_active); end
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b0);
    n_cmp++; if ({wif.word_valid, wif.word_data} !== {1'b1, 32'h44332211}) begin n_err++;
      $display("FAIL bo_first_visible: got v=%b d=%h want v=1 d=44332211", wif.word_valid, wif.word_data); end
    send_byte(8'h55, 1'b0);
    pic_ready = 1'b1;
    tick();
    pic_ready = 1'b0;
    n_cmp++; if ({frame_idx, encoder_active} !== {16'd1, 1'b0}) begin n_err++;
      $display("FAIL bo_frame_end: got idx=%0d act=%b want idx=1 act=0", frame_idx, encoder_active); end
    wait_idle(30, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL bo_idle: got busy=%b want 0", busy); end
    n_cmp++; if (cap_data.size() - q0 !== 2) begin n_err++;
      $display("FAIL bo_count: got %0d words want 2", cap_data.size() - q0); end
    else begin
      n_cmp++; if ({cap_data[q0], cap_bytes[q0], cap_last[q0]} !== {32'h44332211, 3'd4, 1'b0}) begin n_err++;
        $display("FAIL bo_word0: got %h/%0d/%b want 44332211/4/0", cap_data[q0], cap_bytes[q0], cap_last[q0]); end
      n_cmp++; if ({cap_data[q0+1], cap_bytes[q0+1], cap_last[q0+1]} !== {32'h00000055, 3'd1, 1'b1}) begin n_err++;
        $display("FAIL bo_word1: got %h/%0d/%b want 00000055/1/1", cap_data[q0+1], cap_bytes[q0+1], cap_last[q0+1]); end
    end
    n_cmp++; if (done_cnt - d0 !== 1) begin n_err++;
      $display("FAIL bo_done: got %0d pulses want 1", done_cnt - d0); end
  endtask

  task automatic test_coincident_end();
    int q0;
    bit ok;
    q0 = cap_data.size();
    start_run(16'd1);
    for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8);
    wait_idle(30, ok);
    n_cmp++; if (!ok || cap_data.size() - q0 !== 2) begin n_err++;
      $display("FAIL coin_count: got %0d words want 2", cap_data.size() - q0); end
    else begin
      n_cmp++; if ({cap_last[q0], cap_data[q0+1], cap_bytes[q0+1], cap_last[q0+1]} !== {1'b0, 32'h08070605, 3'd4, 1'b1}) begin n_err++;
        $display("FAIL coin_last: got l0=%b %h/%0d/%b want l0=0 08070605/4/1", cap_last[q0], cap_data[q0+1], cap_bytes[q0+1], cap_last[q0+1]); end
    end
    q0 = cap_data.size();
    start_run(16'd1);
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
    pic_ready = 1'b1;
    tick();
    pic_ready = 1'b0;
    wait_idle(30, ok);
    n_cmp++; if (!ok || cap_data.size() - q0 !== 3) begin n_err++;
      $display("FAIL late_count: got %0d words want 3", cap_data.size() - q0); end
    else begin
      n_cmp++; if ({cap_last[q0+1], cap_data[q0+2], cap_bytes[q0+2], cap_last[q0+2]} !== {1'b0, 32'h0, 3'd0, 1'b1}) begin n_err++;
        $display("FAIL late_empty_last: got l1=%b %h/%0d/%b want l1=0 00000000/0/1", cap_last[q0+1], cap_data[q0+2], cap_bytes[q0+2], cap_last[q0+2]); end
    end
  endtask

  task automatic test_multi_frame();
    int q0 = cap_data.size();
    bit ok;
    logic [2:0] exp_bytes [6] = '{3'd4, 3'd4, 3'd2, 3'd4, 3'd2, 3'd4};
    logic       exp_last  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    frames_to_enc = 16'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    cam_vsync = 1'b1;
    n_cmp++; if (encoder_active !== 1'b0) begin n_err++;
      $display("FAIL mf_active_at_edge: got %b want 0", encoder_active); end
    tick();
    cam_vsync = 1'b0;
    n_cmp++; if (encoder_active !== 1'b1) begin n_err++;
      $display("FAIL mf_active_after_edge: got %b want 1", encoder_active); end
    for (int i = 0; i < 10; i++) send_byte(8'(8'h30 + i), i == 9);
    n_cmp++; if ({frame_idx, encoder_active} !== {16'd1, 1'b1}) begin n_err++;
      $display("FAIL mf_frame1: got idx=%0d act=%b want idx=1 act=1", frame_idx, encoder_active); end
    for (int i = 0; i < 6; i++) send_byte(8'(8'h50 + i), i == 5);
    n_cmp++; if ({frame_idx, encoder_active} !== {16'd2, 1'b1}) begin n_err++;
      $display("FAIL mf_frame2: got idx=%0d act=%b want idx=2 act=1", frame_idx, encoder_active); end
    for (int i = 0; i < 3; i++) send_byte(8'(8'h70 + i), 1'b0);
    data_valid = 1'b1; data_out = 8'h73; pic_ready = 1'b1;
    n_cmp++; if (encoder_active !== 1'b1) begin n_err++;
      $display("FAIL mf_active_last_pic: got %b want 1", encoder_active); end
    tick();
    data_valid = 1'b0; pic_ready = 1'b0;
    n_cmp++; if ({frame_idx, encoder_active} !== {16'd3, 1'b0}) begin n_err++;
      $display("FAIL mf_frame3: got idx=%0d act=%b want idx=3 act=0", frame_idx, encoder_active); end
    wait_idle(30, ok);
    n_cmp++; if (!ok || cap_data.size() - q0 !== 6) begin n_err++;
      $display("FAIL mf_count: got %0d words want 6", cap_data.size() - q0); end
    else begin
      for (int k = 0; k < 6; k++) begin
        n_cmp++; if ({cap_bytes[q0+k], cap_last[q0+k]} !== {exp_bytes[k], exp_last[k]}) begin n_err++;
          $display("FAIL mf_word%0d: got bytes=%0d last=%b want bytes=%0d last=%b", k, cap_bytes[q0+k], cap_last[q0+k], exp_bytes[k], exp_last[k]); end
      end
      n_cmp++; if (cap_data[q0+5] !== 32'h73727170) begin n_err++;
        $display("FAIL mf_last_data: got %h want 73727170", cap_data[q0+5]); end
    end
  endtask

  task automatic test_backpressure();
    int q0 = cap_data.size();
    int d0 = done_cnt;
    bit ok;
    logic [31:0] exp_w;
    wif.word_ready = 1'b0;
    start_run(16'd1);
    for (int i = 0; i < 40; i++) begin
      send_byte(8'(i), i == 39);
      if (i == 31) begin
        n_cmp++; if ({wif.word_valid, err_overflow} !== 2'b10) begin n_err++;
          $display("FAIL bp_full_no_ovf: got v=%b ovf=%b want v=1 ovf=0", wif.word_valid, err_overflow); end
      end
      if (i == 35) begin
        n_cmp++; if (err_overflow !== 1'b1) begin n_err++;
          $display("FAIL bp_ovf_9th: got %b want 1", err_overflow); end
      end
    end
    wif.word_ready = 1'b1;
    wait_idle(40, ok);
    n_cmp++; if (!ok || cap_data.size() - q0 !== 8) begin n_err++;
      $display("FAIL bp_count: got %0d words want 8", cap_data.size() - q0); end
    else begin
      for (int k = 0; k < 8; k++) begin
        exp_w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
        n_cmp++; if ({cap_data[q0+k], cap_bytes[q0+k]} !== {exp_w, 3'd4}) begin n_err++;
          $display("FAIL bp_word%0d: got %h/%0d want %h/4", k, cap_data[q0+k], cap_bytes[q0+k], exp_w); end
      end
    end
    n_cmp++; if ({err_overflow, done_cnt - d0 == 1} !== 2'b11) begin n_err++;
      $display("FAIL bp_sticky_done: got ovf=%b done=%0d want ovf=1 done=1", err_overflow, done_cnt - d0); end
  endtask

  task automatic test_watchdog();
    int q0 = cap_data.size();
    int d0 = done_cnt;
    bit ok;
    start_run(16'd1);
    n_cmp++; if (err_overflow !== 1'b0) begin n_err++;
      $display("FAIL wd_ovf_cleared: got %b want 0", err_overflow); end
    for (int i = 0; i < 4; i++) send_byte(8'(8'hA0 + i), 1'b0);
    repeat (15) tick();
    n_cmp++; if ({err_timeout, encoder_active} !== 2'b01) begin n_err++;
      $display("FAIL wd_idle15: got to=%b act=%b want to=0 act=1", err_timeout, encoder_active); end
    tick();
    n_cmp++; if ({err_timeout, encoder_active, busy} !== 3'b101) begin n_err++;
      $display("FAIL wd_idle16: got to=%b act=%b busy=%b want 1/0/1", err_timeout, encoder_active, busy); end
    wait_idle(30, ok);
    n_cmp++; if (!ok || cap_data.size() - q0 !== 1 || done_cnt - d0 !== 1) begin n_err++;
      $display("FAIL wd_drain: got words=%0d done=%0d want words=1 done=1", cap_data.size() - q0, done_cnt - d0); end
    else begin
      n_cmp++; if (cap_data[q0] !== 32'hA3A2A1A0) begin n_err++;
        $display("FAIL wd_word: got %h want a3a2a1a0", cap_data[q0]); end
    end
  endtask

  task automatic test_abort_start_guard();
    int q0 = cap_data.size();
    int d0 = done_cnt;
    bit ok;
    start_run(16'd1);
    for (int i = 0; i < 3; i++) send_byte(8'(8'hE0 + i), 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++; if ({busy, encoder_active, wif.word_valid} !== 3'b000) begin n_err++;
      $display("FAIL ab_idle: got busy/act/valid=%b want 000", {busy, encoder_active, wif.word_valid}); end
    for (int i = 0; i < 4; i++) send_byte(8'(8'hF0 + i), i == 3);
    tick();
    n_cmp++; if ({wif.word_valid, cap_data.size() - q0 == 0, done_cnt - d0 == 0} !== 3'b011) begin n_err++;
      $display("FAIL ab_no_output: got valid=%b words=%0d done=%0d want 0/0/0", wif.word_valid, cap_data.size() - q0, done_cnt - d0); end
    frames_to_enc = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++;
      $display("FAIL zero_frames_start: got busy=%b want 0", busy); end
    frames_to_enc = 16'd1;
    start = 1'b1;
    tick();
    frames_to_enc = 16'd2;
    tick();
    start = 1'b0;
    cam_vsync = 1'b1;
    tick();
    cam_vsync = 1'b0;
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b1);
    n_cmp++; if ({frame_idx, encoder_active} !== {16'd1, 1'b0}) begin n_err++;
      $display("FAIL arm_start_ignored: got idx=%0d act=%b want idx=1 act=0", frame_idx, encoder_active); end
    wait_idle(30, ok);
    n_cmp++; if (!ok || cap_data.size() - q0 !== 1 || done_cnt - d0 !== 1) begin n_err++;
      $display("FAIL guard_run: got words=%0d done=%0d want 1/1", cap_data.size() - q0, done_cnt - d0); end
    else begin
      n_cmp++; if ({cap_data[q0], cap_bytes[q0], cap_last[q0]} !== {32'h0000BBAA, 3'd2, 1'b1}) begin n_err++;
        $display("FAIL guard_word: got %h/%0d/%b want 0000bbaa/2/1", cap_data[q0], cap_bytes[q0], cap_last[q0]); end
    end
  endtask

  task automatic test_reset_midrun();
    wif.word_ready = 1'b0;
    start_run(16'd2);
    for (int i = 0; i < 5; i++) send_byte(8'(i), 1'b0);
    n_cmp++; if (wif.word_valid !== 1'b1) begin n_err++;
      $display("FAIL mr_word_held: got %b want 1", wif.word_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if ({busy, encoder_active, wif.word_valid, frame_idx} !== 19'h0) begin n_err++;
      $display("FAIL mr_reset: got busy=%b act=%b valid=%b idx=%0d want all 0", busy, encoder_active, wif.word_valid, frame_idx); end
    wif.word_ready = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_byte_order();
    test_coincident_end();
    test_multi_frame();
    test_backpressure();
    test_watchdog();
    test_abort_start_guard();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
